// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the ID/EX operand-forwarding stage.
//   XLEN        : default datapath width.
//   SRC_*       : source indices of the forwarding selector
//                 (register file, EX/MEM, MEM/WB, immediate).
//   STALL_CNTW  : default width of the saturating stall counter.
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int XLEN       = 32'd32;
    localparam int STALL_CNTW = 32'd4;

    localparam int SRC_RF     = 32'd0;
    localparam int SRC_EXMEM  = 32'd1;
    localparam int SRC_MEMWB  = 32'd2;
    localparam int SRC_IMM    = 32'd3;

endpackage : pipe_pkg

// File: rtl/mux_n.sv
// ----------------------------------------------------------------------------
// mux_n
// Combinational N-way, WIDTH-bit selector over a packed source bus.
//   in_data  [NSRC*WIDTH] : source k occupies bits [k*WIDTH +: WIDTH]
//   sel      [SELW]       : binary source index
//   out_data [WIDTH]      : selected source (source 0 when sel is out of range)
//   in_range              : high when sel < NSRC
// ----------------------------------------------------------------------------
module mux_n
    import pipe_pkg::*;
#(
    parameter  int WIDTH = XLEN,
    parameter  int NSRC  = 4,
    localparam int SELW  = $clog2(NSRC)
) (
    input  logic [NSRC*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  in_range
);

    // One extra bit so NSRC itself is representable when it is a power of two.
    localparam logic [SELW:0] NSRC_W = (SELW + 1)'(NSRC);

    logic [SELW-1:0] idx_s;

    // Range check, clamp to source 0, then AND-OR select across all sources.
    always_comb begin
        in_range = ({1'b0, sel} < NSRC_W);
        if (in_range) begin
            idx_s = sel;
        end else begin
            idx_s = '0;
        end
        out_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            out_data = out_data
                     | (in_data[k*WIDTH +: WIDTH] & {WIDTH{idx_s == SELW'(k)}});
        end
    end

endmodule : mux_n

// File: rtl/pipe_mux_reg.sv
// ----------------------------------------------------------------------------
// pipe_mux_reg
// Operand selector fused with the ID/EX pipeline register.
//   clk, resetn  : rising-edge clock, asynchronous active-low reset
//   in_valid     : upstream holds a valid instruction
//   in_data      : packed sources, source k at [k*WIDTH +: WIDTH]
//   sel          : source index to capture
//   stall        : hold register contents (counts consecutive stall cycles)
//   flush        : insert a bubble; wins over stall
//   out_valid    : registered valid
//   out_data     : registered selected operand
//   out_sel_err  : registered; captured sel was >= NSRC on a valid load
//   stall_cnt    : consecutive stall cycles, saturating at all-ones
// The stall "state machine" is just stall_cnt: zero is idle, non-zero is hold.
// ----------------------------------------------------------------------------
module pipe_mux_reg
    import pipe_pkg::*;
#(
    parameter  int WIDTH = XLEN,
    parameter  int NSRC  = 4,
    parameter  int CNTW  = STALL_CNTW,
    localparam int SELW  = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic [NSRC*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]       sel,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_sel_err,
    output logic [CNTW-1:0]       stall_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] mux_data_s;
    logic             in_range_s;

    logic             valid_d,     valid_q;
    logic [WIDTH-1:0] data_d,      data_q;
    logic             sel_err_d,   sel_err_q;
    logic [CNTW-1:0]  stall_cnt_d, stall_cnt_q;

    mux_n #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC)
    ) u_mux (
        .in_data  (in_data),
        .sel      (sel),
        .out_data (mux_data_s),
        .in_range (in_range_s)
    );

    // Next-state: flush beats stall beats load.
    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        sel_err_d   = sel_err_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            valid_d     = 1'b0;
            data_d      = '0;
            sel_err_d   = 1'b0;
            stall_cnt_d = '0;
        end else if (stall) begin
            // Payload holds; counter sticks at all-ones instead of wrapping.
            if (stall_cnt_q == CNT_MAX) begin
                stall_cnt_d = CNT_MAX;
            end else begin
                stall_cnt_d = stall_cnt_q + CNTW'(1);
            end
        end else begin
            // Data is captured even for bubbles; the error flag is not.
            valid_d     = in_valid;
            data_d      = mux_data_s;
            sel_err_d   = in_valid & ~in_range_s;
            stall_cnt_d = '0;
        end
    end

    // Pipeline register with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            sel_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            data_q      <= data_d;
            sel_err_q   <= sel_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_sel_err = sel_err_q;
    assign stall_cnt   = stall_cnt_q;

endmodule : pipe_mux_reg

// File: tb/tb_pipe_mux_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_mux_reg
// Directed bench for pipe_mux_reg: one 4-source and one 3-source instance.
// Each step drives inputs, pushes the expected register contents onto a
// scoreboard queue, clocks once and pops/compares against the outputs.
// ----------------------------------------------------------------------------
module tb_pipe_mux_reg;
    import pipe_pkg::*;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic        e;
        logic [3:0]  c;
    } st_t;

    typedef struct {
        int    id;
        string tag;
        st_t   exp;
    } sb_t;

    logic clk = 1'b0;
    logic resetn;

    // 4-source instance
    logic         iv4, st4, fl4;
    logic [127:0] d4;
    logic [1:0]   s4;
    logic         ov4, oe4;
    logic [31:0]  od4;
    logic [3:0]   oc4;

    // 3-source instance
    logic         iv3, st3, fl3;
    logic [95:0]  d3;
    logic [1:0]   s3;
    logic         ov3, oe3;
    logic [31:0]  od3;
    logic [3:0]   oc3;

    logic [127:0] base4;
    int           vectors     = 0;
    int           miscompares = 0;
    st_t          m4;
    st_t          m3;
    sb_t          sbq[$];

    always #5 clk = ~clk;

    pipe_mux_reg #(.WIDTH(32), .NSRC(4), .CNTW(4)) dut4 (
        .clk(clk), .resetn(resetn), .in_valid(iv4), .in_data(d4), .sel(s4),
        .stall(st4), .flush(fl4), .out_valid(ov4), .out_data(od4),
        .out_sel_err(oe4), .stall_cnt(oc4)
    );

    pipe_mux_reg #(.WIDTH(32), .NSRC(3), .CNTW(4)) dut3 (
        .clk(clk), .resetn(resetn), .in_valid(iv3), .in_data(d3), .sel(s3),
        .stall(st3), .flush(fl3), .out_valid(ov3), .out_data(od3),
        .out_sel_err(oe3), .stall_cnt(oc3)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_state(input string tag, input int id, input st_t exp);
        if (id == 4) begin
            cmp({tag, ".valid"}, {31'd0, ov4}, {31'd0, exp.v});
            cmp({tag, ".data"},  od4,          exp.d);
            cmp({tag, ".err"},   {31'd0, oe4}, {31'd0, exp.e});
            cmp({tag, ".cnt"},   {28'd0, oc4}, {28'd0, exp.c});
        end else begin
            cmp({tag, ".valid"}, {31'd0, ov3}, {31'd0, exp.v});
            cmp({tag, ".data"},  od3,          exp.d);
            cmp({tag, ".err"},   {31'd0, oe3}, {31'd0, exp.e});
            cmp({tag, ".cnt"},   {28'd0, oc3}, {28'd0, exp.c});
        end
    endtask

    // Reference behaviour of one clock edge.
    function automatic st_t model(input st_t cur, input int nsrc, input logic [127:0] src,
                                  input logic iv, input logic [1:0] s,
                                  input logic st, input logic fl);
        st_t n = cur;
        if (fl) begin
            n = '0;
        end else if (st) begin
            n.c = (cur.c == 4'hF) ? 4'hF : cur.c + 4'd1;
        end else begin
            n.v = iv;
            if (int'(s) < nsrc) begin
                n.d = src[int'(s)*32 +: 32];
                n.e = 1'b0;
            end else begin
                n.d = src[31:0];
                n.e = iv;
            end
            n.c = 4'd0;
        end
        return n;
    endfunction

    task automatic step(input int id, input string tag, input logic iv, input logic [1:0] s,
                        input logic st, input logic fl);
        sb_t e;
        sb_t got;
        if (id == 4) begin
            iv4 = iv; s4 = s; st4 = st; fl4 = fl;
            m4 = model(m4, 4, d4, iv, s, st, fl);
            e.exp = m4;
        end else begin
            iv3 = iv; s3 = s; st3 = st; fl3 = fl;
            m3 = model(m3, 3, {32'd0, d3}, iv, s, st, fl);
            e.exp = m3;
        end
        e.id  = id;
        e.tag = tag;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        cmp({tag, ".sb_depth"}, 32'(sbq.size()), 32'd1);
        if (sbq.size() != 0) begin
            got = sbq.pop_front();
            cmp_state(got.tag, got.id, got.exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        base4  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        d4     = base4;
        d3     = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        iv4 = 1'b0; s4 = 2'd0; st4 = 1'b0; fl4 = 1'b0;
        iv3 = 1'b0; s3 = 2'd0; st3 = 1'b0; fl3 = 1'b1;   // idle bubble source
        m4 = '0;
        m3 = '0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #10;
        cmp_state("por4", 4, '0);
        cmp_state("por3", 3, '0);
        resetn = 1'b1;

        // Select sweep over all four forwarding sources.
        for (int k = 0; k < 4; k++) begin
            step(4, $sformatf("sweep%0d", k), 1'b1, 2'(k), 1'b0, 1'b0);
        end
        cmp("sweep_last_const", od4, 32'h44444444);

        // Bubble still captures data.
        step(4, "bubble", 1'b0, 2'(SRC_EXMEM), 1'b0, 1'b0);

        // Stall hold and saturation while sources churn.
        step(4, "ld_memwb", 1'b1, 2'(SRC_MEMWB), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            d4 = {$urandom, $urandom, $urandom, $urandom};
            step(4, $sformatf("stall%0d", i), $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                 1'b1, 1'b0);
        end
        cmp("stall_hold_const", od4, 32'h33333333);
        cmp("stall_sat_const", {28'd0, oc4}, 32'd15);
        d4 = base4;
        step(4, "release", 1'b1, 2'(SRC_IMM), 1'b0, 1'b0);

        // Flush beats stall.
        step(4, "ld_rf", 1'b1, 2'(SRC_RF), 1'b0, 1'b0);
        step(4, "pre_fl", 1'b1, 2'(SRC_RF), 1'b1, 1'b0);
        step(4, "flush_st", 1'b1, 2'(SRC_IMM), 1'b1, 1'b1);

        // Mid-cycle async reset with valid data and stall_cnt=3.
        step(4, "ld_rst", 1'b1, 2'(SRC_EXMEM), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4, $sformatf("rst_st%0d", i), 1'b0, 2'd0, 1'b1, 1'b0);
        end
        #2 resetn = 1'b0;
        #1;
        m4 = '0;
        m3 = '0;
        cmp_state("async_rst", 4, '0);
        resetn = 1'b1;
        step(4, "post_rst", 1'b0, 2'd0, 1'b0, 1'b0);

        // Out-of-range select on the 3-source instance.
        fl4 = 1'b1;
        step(3, "oor_v",  1'b1, 2'd3, 1'b0, 1'b0);
        step(3, "oor_nv", 1'b0, 2'd3, 1'b0, 1'b0);
        step(3, "oor_v2", 1'b1, 2'd3, 1'b0, 1'b0);
        step(3, "sel2",   1'b1, 2'd2, 1'b0, 1'b0);
        step(3, "n3_st",  1'b1, 2'd3, 1'b1, 1'b0);
        step(3, "n3_bub", 1'b0, 2'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pipe_mux_reg
